// File: rtl/fp_sqrt_if.sv
// rtl/fp_sqrt_if.sv - operand/result bundle for the fp_sqrt binary64 square-root unit
// Master side supplies the unpacked operand, slave side returns the unpacked result.
interface fp_sqrt_if;
  logic        i_sign;
  logic [10:0] i_exp;
  logic [51:0] i_frac;
  logic        ready;
  logic        o_sign;
  logic [10:0] o_exp;
  logic [51:0] o_frac;

  modport master (
    output i_sign, i_exp, i_frac,
    input  ready, o_sign, o_exp, o_frac
  );

  modport slave (
    input  i_sign, i_exp, i_frac,
    output ready, o_sign, o_exp, o_frac
  );
endinterface

// File: rtl/fp_sqrt.sv
// rtl/fp_sqrt.sv - sequential binary64 square root, restoring one root bit per cycle
// Reset release acts as start; the result appears 56 rising edges later and holds until reset.
module fp_sqrt (
  input  logic     clk,
  input  logic     reset,
  fp_sqrt_if.slave sq
);

  typedef enum logic [1:0] {S_LOAD, S_ITER, S_ROUND, S_DONE} state_t;

  state_t        state_q;
  logic [5:0]    cnt_q;
  logic [107:0]  rad_q;
  logic [55:0]   rem_q;
  logic [53:0]   root_q;
  logic [10:0]   half_q;
  logic          spec_q;
  logic          sp_sign_q;
  logic [10:0]   sp_exp_q;
  logic [51:0]   sp_frac_q;
  logic          ready_q;
  logic          o_sign_q;
  logic [10:0]   o_exp_q;
  logic [51:0]   o_frac_q;

  logic          spec_d;
  logic          sp_sign_d;
  logic [10:0]   sp_exp_d;
  logic [51:0]   sp_frac_d;
  logic [11:0]   e_unb;
  logic [52:0]   mant;
  logic [107:0]  rad_d;
  logic [57:0]   rem_sh;
  logic [55:0]   trial;
  logic [55:0]   rem_d;
  logic [53:0]   root_d;
  logic          round_up;
  logic [53:0]   rnd;
  logic          carry;
  logic [51:0]   frac_rnd;
  logic [10:0]   exp_rnd;

  // Classification priority: NaN, zero/subnormal (sign kept), negative, +Inf, normal.
  always_comb begin
    spec_d    = 1'b1;
    sp_sign_d = 1'b0;
    sp_exp_d  = 11'h7FF;
    sp_frac_d = 52'h8000000000000;
    if (sq.i_exp == 11'h7FF && sq.i_frac != 52'd0) begin
      sp_sign_d = sq.i_sign;
      sp_frac_d = sq.i_frac | 52'h8000000000000;
    end else if (sq.i_exp == 11'd0) begin
      sp_sign_d = sq.i_sign;
      sp_exp_d  = 11'd0;
      sp_frac_d = 52'd0;
    end else if (sq.i_sign) begin
      sp_frac_d = 52'h8000000000000;
    end else if (sq.i_exp == 11'h7FF) begin
      sp_frac_d = 52'd0;
    end else begin
      spec_d = 1'b0;
    end
  end

  // Odd exponents fold one factor of two into the radicand so the halved exponent is exact.
  assign e_unb = {1'b0, sq.i_exp} - 12'd1023;
  assign mant  = {1'b1, sq.i_frac};
  assign rad_d = e_unb[0] ? {mant, 55'd0} : {1'b0, mant, 54'd0};

  assign rem_sh = {rem_q, rad_q[107:106]};
  assign trial  = {root_q, 2'b01};

  always_comb begin
    if (rem_sh >= {2'b00, trial}) begin
      rem_d  = rem_sh[55:0] - trial;
      root_d = {root_q[52:0], 1'b1};
    end else begin
      rem_d  = rem_sh[55:0];
      root_d = {root_q[52:0], 1'b0};
    end
  end

  assign round_up = root_q[0] & ((|rem_q) | root_q[1]);
  assign rnd      = {1'b0, root_q[53:1]} + {53'd0, round_up};
  assign carry    = rnd[53];
  assign frac_rnd = carry ? rnd[52:1] : rnd[51:0];
  assign exp_rnd  = half_q + 11'd1023 + {10'd0, carry};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      half_q    <= '0;
      spec_q    <= 1'b0;
      sp_sign_q <= 1'b0;
      sp_exp_q  <= '0;
      sp_frac_q <= '0;
      ready_q   <= 1'b0;
      o_sign_q  <= 1'b0;
      o_exp_q   <= '0;
      o_frac_q  <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          spec_q    <= spec_d;
          sp_sign_q <= sp_sign_d;
          sp_exp_q  <= sp_exp_d;
          sp_frac_q <= sp_frac_d;
          half_q    <= e_unb[11:1];
          rad_q     <= rad_d;
          rem_q     <= '0;
          root_q    <= '0;
          cnt_q     <= '0;
          state_q   <= S_ITER;
        end
        S_ITER: begin
          rad_q  <= {rad_q[105:0], 2'b00};
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'd53) state_q <= S_ROUND;
        end
        S_ROUND: begin
          ready_q <= 1'b1;
          if (spec_q) begin
            o_sign_q <= sp_sign_q;
            o_exp_q  <= sp_exp_q;
            o_frac_q <= sp_frac_q;
          end else begin
            o_sign_q <= 1'b0;
            o_exp_q  <= exp_rnd;
            o_frac_q <= frac_rnd;
          end
          state_q <= S_DONE;
        end
        default: state_q <= S_DONE;
      endcase
    end
  end

  assign sq.ready  = ready_q;
  assign sq.o_sign = o_sign_q;
  assign sq.o_exp  = o_exp_q;
  assign sq.o_frac = o_frac_q;

endmodule

// File: tb/tb_fp_sqrt.sv
// tb/tb_fp_sqrt.sv - self-checking bench for fp_sqrt against a real-arithmetic reference
// Directed cases use known constants; random cases use a model built on $sqrt of the decoded double.
module tb_fp_sqrt;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fp_sqrt_if bus ();

  fp_sqrt u_dut (
    .clk   (clk),
    .reset (reset),
    .sq    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, want);
    end
  endtask

  // IEEE sqrt is correctly rounded, so the host double result is the golden value for normals.
  function automatic logic [63:0] ref_sqrt(input logic s, input logic [10:0] e, input logic [51:0] f);
    real r;
    if (e == 11'h7FF && f != 52'd0) return {s, 11'h7FF, f | 52'h8000000000000};
    if (e == 11'd0)                 return {s, 63'd0};
    if (s)                          return {1'b0, 11'h7FF, 52'h8000000000000};
    if (e == 11'h7FF)               return {1'b0, 11'h7FF, 52'd0};
    r = $bitstoreal({s, e, f});
    return $realtobits($sqrt(r));
  endfunction

  task automatic run_op(input string tag, input logic s, input logic [10:0] e,
                        input logic [51:0] f, input logic [63:0] want);
    @(negedge clk);
    reset      = 1'b0;
    bus.i_sign = s;
    bus.i_exp  = e;
    bus.i_frac = f;
    @(negedge clk);
    reset = 1'b1;
    repeat (55) @(posedge clk);
    #1;
    check({tag, "_rdy_early"}, {63'd0, bus.ready}, 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_rdy"},  {63'd0, bus.ready},  64'd1);
    check({tag, "_sign"}, {63'd0, bus.o_sign}, {63'd0, want[63]});
    check({tag, "_exp"},  {53'd0, bus.o_exp},  {53'd0, want[62:52]});
    check({tag, "_frac"}, {12'd0, bus.o_frac}, {12'd0, want[51:0]});
  endtask

  initial begin
    logic        rs;
    logic [10:0] re;
    logic [63:0] rbits;
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    bus.i_sign = 1'b0;
    bus.i_exp  = 11'h403;
    bus.i_frac = 52'h9000000000000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {bus.ready, bus.o_sign, bus.o_exp, bus.o_frac}, 64'd0);

    run_op("sq25", 1'b0, 11'h403, 52'h9000000000000, {1'b0, 11'h401, 52'h4000000000000});

    // Result holds after completion, then an asynchronous reset clears it.
    repeat (4) @(posedge clk);
    #1;
    check("hold", {bus.ready, bus.o_sign, bus.o_exp, bus.o_frac}, {1'b1, 1'b0, 11'h401, 52'h4000000000000});
    reset = 1'b0;
    #1;
    check("rst_clear", {bus.ready, bus.o_sign, bus.o_exp, bus.o_frac}, 64'd0);

    // Abort partway through, change operand while held in reset.
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    reset      = 1'b0;
    bus.i_exp  = 11'h402;
    bus.i_frac = 52'h8800000000000;
    repeat (3) @(posedge clk);
    #1;
    check("abort_zero", {bus.ready, bus.o_sign, bus.o_exp, bus.o_frac}, 64'd0);
    run_op("sq1225", 1'b0, 11'h402, 52'h8800000000000, {1'b0, 11'h400, 52'hC000000000000});

    run_op("sqrt2",  1'b0, 11'h400, 52'd0,             {1'b0, 11'h3FF, 52'h6A09E667F3BCD});
    run_op("below2", 1'b0, 11'h3FF, 52'hFFFFFFFFFFFFF, {1'b0, 11'h3FF, 52'h6A09E667F3BCC});
    run_op("pzero",  1'b0, 11'h000, 52'd0,             {1'b0, 11'h000, 52'd0});
    run_op("nzero",  1'b1, 11'h000, 52'd0,             {1'b1, 11'h000, 52'd0});
    run_op("pinf",   1'b0, 11'h7FF, 52'd0,             {1'b0, 11'h7FF, 52'd0});
    run_op("ninf",   1'b1, 11'h7FF, 52'd0,             {1'b0, 11'h7FF, 52'h8000000000000});
    run_op("neg4",   1'b1, 11'h401, 52'd0,             {1'b0, 11'h7FF, 52'h8000000000000});
    run_op("snan",   1'b0, 11'h7FF, 52'h0000000000001, {1'b0, 11'h7FF, 52'h8000000000001});
    run_op("subn",   1'b0, 11'h000, 52'h0000000012345, {1'b0, 11'h000, 52'd0});

    for (int i = 0; i < 40; i++) begin
      rbits = {$urandom, $urandom};
      rs    = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0:       re = 11'h000;
        1:       re = 11'h7FF;
        default: re = 11'($urandom_range(1, 2046));
      endcase
      if ($urandom_range(0, 3) == 0) rbits[51:0] = 52'd0;
      run_op($sformatf("rnd%0d", i), rs, re, rbits[51:0], ref_sqrt(rs, re, rbits[51:0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
